alu_pipe_mc: RTL
================

// Module: alu_pipe_mc
// PURPOSE
//  Parametrised, registered successor of the core combinational ALU. Accepts one op per
//  cycle on a valid/ready interface. Single-cycle ops complete in 1 clock. DIV runs on an
//  iterative restoring divider over REG_W clocks.
//  Sits in the core X stage; lets the core stall on DIV instead of closing timing on a
//  combinational divider.
// PARAMETERS
//  REG_W    8  operand/result width (bits)
//  CID_W    4  core_id width; must be <= REG_W
//  OPC_W    4  opcode width; opcode values come from the core opcode defines
// PORTS
//  clk          in   1      core clock, rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  in_valid     in   1      op, src0, src1, const, mode are valid this cycle
//  in_ready     out  1      block can accept an op this cycle
//  in_opc       in   OPC_W  opcode: ADD SUB MUL DIV CMPGE RSHIFT LSHIFT AND OR XOR SET_CONST LD ST
//  in_src0      in   REG_W  operand 0
//  in_src1      in   REG_W  operand 1
//  in_const     in   REG_W  F2 immediate for SET_CONST
//  in_const_md  in   1      SET_CONST: 1 = in_const, 0 = zero-extended core_id
//  core_id      in   CID_W  this core's id (quasi-static)
//  out_valid    out  1      out_result holds a completed result
//  out_ready    in   1      consumer takes the result this cycle
//  out_result   out  REG_W  registered result
//  out_err      out  1      present only with ALU_PIPE_MC_ERR_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, out_result=0, out_err=0, divider regs=0, iter cnt=0.
//    in_ready=1 once reset_n deasserts.
//  Reset is async. Asserting reset_n mid-DIV aborts the op; no result is ever issued for it.
//  Accept: an op is taken when in_valid & in_ready.
//    in_ready = (state==IDLE) & (~out_valid | out_ready).
//  Output register: out_valid stays high and out_result stays stable until out_ready.
//    Simultaneous pop + accept is allowed, giving throughput 1 op/clk for non-DIV ops.
//  States:
//    IDLE -> IDLE on a non-DIV op. Result is loaded next edge; out_valid=1.
//    IDLE -> DIV on DIV with src1!=0. Latches dividend/divisor; cnt=REG_W-1.
//    DIV: one restoring step per clk (shift remainder, trial-subtract, set quotient bit).
//      At cnt==0, load quotient into out_result, set out_valid=1, go to DONE.
//    DONE -> IDLE when the DIV result is popped (out_valid & out_ready).
//      in_ready=0 in DONE, so the pop and a new accept cannot share a cycle here.
//  Latency (accept edge -> out_valid high): non-DIV = 1 clk; DIV = REG_W+1 clk;
//    DIV by zero = 1 clk.
//  Arithmetic, all unsigned, modulo 2^REG_W:
//    ADD / SUB / MUL: low REG_W bits.
//    CMPGE: {0..0, src0>=src1}.
//    AND / OR / XOR: bitwise.
//    SHIFTs: full src1 is the shift amount; src1 >= REG_W gives 0.
//    LD / ST: pass src0 (the address).
//    SET_CONST: in_const or the zero-extended core_id, selected by in_const_md.
//    Unknown opcode: result 0, still completes in 1 clk.
//  DIV by zero: quotient = all ones, no iteration.
//  in_* are sampled only at the accept edge; changes while in_ready=0 are ignored.
// CONFIGURATION
//  ALU_PIPE_MC_ERR_EN defined:
//    - port out_err exists and is registered alongside out_result, valid with out_valid.
//    - out_err=1 for DIV by zero or an unknown opcode, else 0.
//  ALU_PIPE_MC_ERR_EN undefined:
//    - no out_err port and no error logic.
//    - DIV by zero still returns all ones; unknown opcode still returns 0.
// TESTING  (REG_W=8 unless noted)
//  1. ADD 200+100, out_ready=1 -> out_valid next clk, result 44. SUB 3-5 -> 254.
//     CMPGE 5,5 -> 1.
//  2. Back-to-back: 8 non-DIV ops on 8 consecutive clks with out_ready=1 -> in_ready
//     stays 1; 8 results on 8 consecutive clks, in order.
//  3. DIV 200/7 -> in_ready low 9 clks, result 28 exactly 9 clks after accept.
//     DIV 5/0 -> 255 after 1 clk, out_err=1 with ERR_EN.
//  4. Backpressure: out_ready=0 for 5 clks after ADD 1+1 -> out_result holds 2,
//     in_ready=0; raise out_ready with a new op -> pop and accept in the same clk.
//  5. Shifts/const: LSHIFT 1<<8 -> 0; RSHIFT 128>>7 -> 1;
//     SET_CONST md=0, core_id=5 -> 5; md=1, const=0xA5 -> 0xA5.
//  6. Reset mid-DIV: assert reset_n=0 at iteration 4 of 200/7 -> out_valid=0
//     immediately; after release in_ready=1 and no stale result ever appears.

Source files
------------

// File: rtl/alu_pipe_mc.sv
// -----------------------------------------------------------------------------
// alu_pipe_mc
//
// Registered, multi-cycle ALU for the core X stage. It accepts one op per clock
// on a valid/ready handshake and holds each result in an output register until
// the consumer takes it.
//   - Single-cycle ops (ADD SUB MUL CMPGE shifts AND OR XOR SET_CONST LD ST,
//     unknown opcodes, DIV by zero) are computed from the inputs and loaded
//     straight into the output register at the accept edge.
//   - DIV with a non-zero divisor runs an iterative restoring divider, one
//     quotient bit per clock, so the core stalls on DIV instead of having to
//     close timing on a combinational divider.
//
// Optional feature (compile-time macro ALU_PIPE_MC_ERR_EN):
//   defined   -> port out_err exists; it is registered with out_result and is 1
//                for DIV by zero or an unknown opcode.
//   undefined -> no out_err port and no error logic.
//
// Parameters
//   REG_W  operand/result width
//   CID_W  core_id width (must be <= REG_W)
//   OPC_W  opcode width
//
// Ports
//   clk          in   core clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   in_valid     in   op and operands are valid this cycle
//   in_ready     out  block can accept an op this cycle
//   in_opc       in   opcode
//   in_src0      in   operand 0
//   in_src1      in   operand 1 (divisor / shift amount)
//   in_const     in   SET_CONST immediate
//   in_const_md  in   SET_CONST select: 1 = in_const, 0 = zero-extended core_id
//   core_id      in   this core's id (quasi-static)
//   out_valid    out  out_result holds a completed result
//   out_ready    in   consumer takes the result this cycle
//   out_result   out  registered result
//   out_err      out  error flag (only with ALU_PIPE_MC_ERR_EN)
// -----------------------------------------------------------------------------
module alu_pipe_mc #(
    parameter int REG_W = 8,
    parameter int CID_W = 4,
    parameter int OPC_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] in_opc,
    input  logic [REG_W-1:0] in_src0,
    input  logic [REG_W-1:0] in_src1,
    input  logic [REG_W-1:0] in_const,
    input  logic             in_const_md,
    input  logic [CID_W-1:0] core_id,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REG_W-1:0] out_result
`ifdef ALU_PIPE_MC_ERR_EN
    ,
    output logic             out_err
`endif
);

    // Core opcode encoding.
    localparam logic [OPC_W-1:0] OPC_ADD       = OPC_W'(0);
    localparam logic [OPC_W-1:0] OPC_SUB       = OPC_W'(1);
    localparam logic [OPC_W-1:0] OPC_MUL       = OPC_W'(2);
    localparam logic [OPC_W-1:0] OPC_DIV       = OPC_W'(3);
    localparam logic [OPC_W-1:0] OPC_CMPGE     = OPC_W'(4);
    localparam logic [OPC_W-1:0] OPC_RSHIFT    = OPC_W'(5);
    localparam logic [OPC_W-1:0] OPC_LSHIFT    = OPC_W'(6);
    localparam logic [OPC_W-1:0] OPC_AND       = OPC_W'(7);
    localparam logic [OPC_W-1:0] OPC_OR        = OPC_W'(8);
    localparam logic [OPC_W-1:0] OPC_XOR       = OPC_W'(9);
    localparam logic [OPC_W-1:0] OPC_SET_CONST = OPC_W'(10);
    localparam logic [OPC_W-1:0] OPC_LD        = OPC_W'(11);
    localparam logic [OPC_W-1:0] OPC_ST        = OPC_W'(12);

    localparam int               CNT_W     = (REG_W > 1) ? $clog2(REG_W) : 1;
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(REG_W - 1);
    // Shift amounts at or above this limit flush the result to zero.
    localparam logic [REG_W:0]   SHAMT_LIM = (REG_W + 1)'(REG_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [REG_W-1:0]   out_result_q, out_result_d;
    logic [REG_W-1:0]   rem_q, rem_d;      // partial remainder
    logic [REG_W-1:0]   quo_q, quo_d;      // dividend shifting out / quotient shifting in
    logic [REG_W-1:0]   dvs_q, dvs_d;      // divisor
    logic [CNT_W-1:0]   cnt_q, cnt_d;      // remaining iterations - 1

    logic               accept;
    logic               is_div;
    logic               div_zero;
    logic               start_div;         // accepted DIV that needs iterations
    logic [REG_W-1:0]   alu_result;
    logic [2*REG_W-1:0] mul_full;

    // Restoring divider step signals.
    logic [REG_W:0]     rem_sh;
    logic [REG_W:0]     trial;
    logic               fits;
    logic [REG_W-1:0]   rem_step;
    logic [REG_W-1:0]   quo_step;

    assign accept    = in_valid & in_ready;
    assign is_div    = (in_opc == OPC_DIV);
    assign div_zero  = (in_src1 == '0);
    assign start_div = accept & is_div & ~div_zero;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_div) begin
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // A new op can enter when idle and the output register is empty or being
    // drained in the same cycle. DONE keeps in_ready low so the DIV result pop
    // never coincides with an accept.
    // ---------------------------------------------------------------------
    always_comb begin
        in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    end

    // ---------------------------------------------------------------------
    // Single-cycle result
    // ---------------------------------------------------------------------
    assign mul_full = {{REG_W{1'b0}}, in_src0} * {{REG_W{1'b0}}, in_src1};

    always_comb begin
        alu_result = '0;
        case (in_opc)
            OPC_ADD:   alu_result = in_src0 + in_src1;
            OPC_SUB:   alu_result = in_src0 - in_src1;
            OPC_MUL:   alu_result = mul_full[REG_W-1:0];
            // Only reaches the output register for a zero divisor.
            OPC_DIV:   alu_result = '1;
            OPC_CMPGE: alu_result[0] = (in_src0 >= in_src1);
            OPC_RSHIFT: begin
                if ({1'b0, in_src1} < SHAMT_LIM) begin
                    alu_result = in_src0 >> in_src1;
                end
            end
            OPC_LSHIFT: begin
                if ({1'b0, in_src1} < SHAMT_LIM) begin
                    alu_result = in_src0 << in_src1;
                end
            end
            OPC_AND:   alu_result = in_src0 & in_src1;
            OPC_OR:    alu_result = in_src0 | in_src1;
            OPC_XOR:   alu_result = in_src0 ^ in_src1;
            OPC_SET_CONST: begin
                alu_result = in_const_md ? in_const : REG_W'(core_id);
            end
            OPC_LD:    alu_result = in_src0;
            OPC_ST:    alu_result = in_src0;
            default:   alu_result = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Restoring divider step: shift the next dividend bit into the remainder,
    // trial-subtract the divisor and keep the difference if it did not borrow.
    // ---------------------------------------------------------------------
    always_comb begin
        rem_sh   = {rem_q, quo_q[REG_W-1]};
        trial    = rem_sh - {1'b0, dvs_q};
        fits     = ~trial[REG_W];
        rem_step = fits ? trial[REG_W-1:0] : rem_sh[REG_W-1:0];
        quo_step = {quo_q[REG_W-2:0], fits};
    end

    // ---------------------------------------------------------------------
    // Datapath next-state
    // ---------------------------------------------------------------------
    always_comb begin
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvs_d        = dvs_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;

        // Pop first; a load in the same cycle below takes precedence.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (start_div) begin
            rem_d = '0;
            quo_d = in_src0;
            dvs_d = in_src1;
            cnt_d = CNT_START;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
        end

        if (state_q == S_DIV) begin
            rem_d = rem_step;
            quo_d = quo_step;
            if (cnt_q == '0) begin
                out_valid_d  = 1'b1;
                out_result_d = quo_step;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvs_q        <= '0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dvs_q        <= dvs_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;

`ifdef ALU_PIPE_MC_ERR_EN
    // ---------------------------------------------------------------------
    // Error flag: loaded together with out_result. Set for an unknown opcode
    // or a zero divisor; an iterated DIV always completes cleanly.
    // ---------------------------------------------------------------------
    logic err_q, err_d;
    logic op_known;

    always_comb begin
        op_known = (in_opc <= OPC_ST);
    end

    always_comb begin
        err_d = err_q;
        if (accept && !start_div) begin
            err_d = ~op_known | (is_div & div_zero);
        end
        if ((state_q == S_DIV) && (cnt_q == '0)) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign out_err = err_q;
`endif

endmodule
